// File: rtl/fht_pkg.sv
// Shared constants and state encoding for the FHT stage sequencer.
// Imported by the controller and its delay line.
package fht_pkg;

   localparam int N_BIT_DEF    = 11;
   localparam int A_BIT_DEF    = N_BIT_DEF - 2;
   localparam int PIPE_LAT_DEF = 4;
   localparam int N_STAGE_DEF  = N_BIT_DEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fht_state_t;

endpackage

// File: rtl/fht_dly_line.sv
// Fixed-depth register delay line with asynchronous active-low clear.
// Carries the write enable/address and the subsector flag.
module fht_dly_line
   import fht_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sr [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fht_stage_ctrl.sv
// Stage/sector sequencer for the in-place FHT engine: bank addressing,
// butterfly control flags and twiddle ROM address.
module fht_stage_ctrl
   import fht_pkg::*;
#(
   parameter int N_BIT    = N_BIT_DEF,
   parameter int A_BIT    = N_BIT - 2,
   parameter int SEC_BIT  = 9,
   parameter int ST_BIT   = 4,
   parameter int PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic               iCLK,
   input  logic               iRESET,
   input  logic               iSTART,
   output logic               oBUSY,
   output logic               oDONE,
   output logic               oRD_EN,
   output logic [A_BIT-1:0]   oRD_ADDR,
   output logic               oWR_EN,
   output logic [A_BIT-1:0]   oWR_ADDR,
   output logic [ST_BIT-1:0]  oSTAGE,
   output logic               oST_ZERO,
   output logic               oST_LAST,
   output logic               o2ND_PART_SUBSEC,
   output logic [SEC_BIT-1:0] oSECTOR,
   output logic [A_BIT-1:0]   oTW_ADDR
);

   localparam int DW = $clog2(PIPE_LAT);
   localparam logic [ST_BIT-1:0] LAST_ST = ST_BIT'(N_BIT - 1);
   localparam logic [ST_BIT-1:0] A_ST    = ST_BIT'(A_BIT);
   localparam logic [A_BIT-1:0]  CNT_MAX = '1;
   localparam logic [DW-1:0]     DRN_MAX = DW'(PIPE_LAT - 1);

   fht_state_t        state, state_n;
   logic [A_BIT-1:0]  rd_cnt, rd_cnt_n;
   logic [ST_BIT-1:0] stage, stage_n;
   logic [DW-1:0]     drn_cnt, drn_cnt_n;

   logic               busy_n, rd_en_n, done_n;
   logic [ST_BIT-1:0]  m_n;
   logic [A_BIT-1:0]   sec_full, tw_mask, tw_n, sub_sh;
   logic [SEC_BIT-1:0] sec_n;
   logic               sub_raw_n, sub_raw;
   logic [A_BIT:0]     wr_bus;

   always_comb begin
      state_n   = state;
      rd_cnt_n  = rd_cnt;
      stage_n   = stage;
      drn_cnt_n = drn_cnt;
      unique case (state)
         IDLE: begin
            if (iSTART) begin
               state_n  = READ;
               stage_n  = '0;
               rd_cnt_n = '0;
            end
         end
         READ: begin
            rd_cnt_n = rd_cnt + 1'b1;
            if (rd_cnt == CNT_MAX) begin
               state_n   = DRAIN;
               drn_cnt_n = '0;
            end
         end
         DRAIN: begin
            drn_cnt_n = drn_cnt + 1'b1;
            if (drn_cnt == DRN_MAX) begin
               if (stage == LAST_ST) begin
                  state_n = DONE;
               end else begin
                  state_n = READ;
                  stage_n = stage + 1'b1;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
            stage_n = '0;
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are computed from next-state values so they can be registered
   // without adding a cycle of latency.
   always_comb begin
      busy_n    = (state_n == READ) || (state_n == DRAIN);
      rd_en_n   = (state_n == READ);
      done_n    = (state_n == DONE);
      m_n       = (stage_n < A_ST) ? stage_n : A_ST;
      sec_full  = rd_cnt_n >> m_n;
      sec_n     = SEC_BIT'(sec_full);
      tw_mask   = ~(CNT_MAX << m_n);
      tw_n      = rd_en_n ? ((rd_cnt_n & tw_mask) << (A_ST - m_n)) : '0;
      sub_sh    = '0;
      sub_raw_n = 1'b0;
      if ((stage_n != '0) && (stage_n <= A_ST)) begin
         sub_sh    = rd_cnt_n >> (stage_n - 1'b1);
         sub_raw_n = sub_sh[0];
      end
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state    <= IDLE;
         rd_cnt   <= '0;
         stage    <= '0;
         drn_cnt  <= '0;
         oBUSY    <= 1'b0;
         oDONE    <= 1'b0;
         oRD_EN   <= 1'b0;
         oRD_ADDR <= '0;
         oSTAGE   <= '0;
         oST_ZERO <= 1'b0;
         oST_LAST <= 1'b0;
         oSECTOR  <= '0;
         oTW_ADDR <= '0;
         sub_raw  <= 1'b0;
      end else begin
         state    <= state_n;
         rd_cnt   <= rd_cnt_n;
         stage    <= stage_n;
         drn_cnt  <= drn_cnt_n;
         oBUSY    <= busy_n;
         oDONE    <= done_n;
         oRD_EN   <= rd_en_n;
         oRD_ADDR <= rd_en_n ? rd_cnt_n : '0;
         oSTAGE   <= busy_n ? stage_n : '0;
         oST_ZERO <= busy_n && (stage_n == '0);
         oST_LAST <= busy_n && (stage_n == LAST_ST);
         oSECTOR  <= sec_n;
         oTW_ADDR <= tw_n;
         sub_raw  <= sub_raw_n;
      end
   end

   fht_dly_line #(
      .WIDTH (A_BIT + 1),
      .DEPTH (PIPE_LAT)
   ) u_wr_dly (
      .clk   (iCLK),
      .rst_n (iRESET),
      .din   ({oRD_EN, oRD_ADDR}),
      .dout  (wr_bus)
   );

   assign {oWR_EN, oWR_ADDR} = wr_bus;

   // One cycle shorter: the flag must be ready at the mixer-load edge.
   fht_dly_line #(
      .WIDTH (1),
      .DEPTH (PIPE_LAT - 1)
   ) u_sub_dly (
      .clk   (iCLK),
      .rst_n (iRESET),
      .din   (sub_raw),
      .dout  (o2ND_PART_SUBSEC)
   );

endmodule

// File: tb/tb_fht_stage_ctrl.sv
// Bench for fht_stage_ctrl: directed scenario then random start/reset
// traffic, checked against a run-time-indexed reference model.
module tb_fht_stage_ctrl;

   localparam int N   = 4;
   localparam int A   = 2;
   localparam int SB  = 3;
   localparam int STB = 3;
   localparam int PL  = 4;
   localparam int W   = 1 << A;
   localparam int S   = W + PL;
   localparam int RUN = N * S;

   logic           iCLK, iRESET, iSTART;
   logic           oBUSY, oDONE, oRD_EN, oWR_EN;
   logic [A-1:0]   oRD_ADDR, oWR_ADDR, oTW_ADDR;
   logic [STB-1:0] oSTAGE;
   logic           oST_ZERO, oST_LAST, o2ND_PART_SUBSEC;
   logic [SB-1:0]  oSECTOR;

   typedef struct packed {
      logic           busy, done, rd_en, wr_en;
      logic [A-1:0]   rd_addr, wr_addr, tw;
      logic [STB-1:0] stage;
      logic           zero, last, sub;
      logic [SB-1:0]  sec;
   } exp_t;

   int tests = 0;
   int fails = 0;
   int t = -1;

   fht_stage_ctrl #(
      .N_BIT(N), .A_BIT(A), .SEC_BIT(SB), .ST_BIT(STB), .PIPE_LAT(PL)
   ) dut (
      .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
      .oBUSY(oBUSY), .oDONE(oDONE),
      .oRD_EN(oRD_EN), .oRD_ADDR(oRD_ADDR),
      .oWR_EN(oWR_EN), .oWR_ADDR(oWR_ADDR),
      .oSTAGE(oSTAGE), .oST_ZERO(oST_ZERO), .oST_LAST(oST_LAST),
      .o2ND_PART_SUBSEC(o2ND_PART_SUBSEC),
      .oSECTOR(oSECTOR), .oTW_ADDR(oTW_ADDR)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   // t = cycles since the run's first read cycle; -1 when idle.
   function automatic exp_t model(int tt);
      exp_t e;
      int st, pos, m, p;
      e = '0;
      if (tt < 0) return e;
      if (tt == RUN) begin
         e.done = 1'b1;
         return e;
      end
      st  = tt / S;
      pos = tt % S;
      m   = (st < A) ? st : A;
      e.busy  = 1'b1;
      e.stage = STB'(st);
      e.zero  = (st == 0);
      e.last  = (st == N - 1);
      if (pos < W) begin
         e.rd_en   = 1'b1;
         e.rd_addr = A'(pos);
         e.sec     = SB'(pos / (1 << m));
         e.tw      = A'((pos % (1 << m)) * (1 << (A - m)));
      end
      if (pos >= PL && pos - PL < W) begin
         e.wr_en   = 1'b1;
         e.wr_addr = A'(pos - PL);
      end
      p = pos - (PL - 1);
      if (p >= 0 && p < W && st >= 1 && st <= A)
         e.sub = ((p / (1 << (st - 1))) % 2) == 1;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         if (fails <= 30)
            $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp);
      end
   endtask

   task automatic check_all();
      exp_t e;
      e = model(t);
      chk("busy",   16'(oBUSY),            16'(e.busy));
      chk("done",   16'(oDONE),            16'(e.done));
      chk("rd_en",  16'(oRD_EN),           16'(e.rd_en));
      chk("rd_adr", 16'(oRD_ADDR),         16'(e.rd_addr));
      chk("wr_en",  16'(oWR_EN),           16'(e.wr_en));
      chk("wr_adr", 16'(oWR_ADDR),         16'(e.wr_addr));
      chk("stage",  16'(oSTAGE),           16'(e.stage));
      chk("zero",   16'(oST_ZERO),         16'(e.zero));
      chk("last",   16'(oST_LAST),         16'(e.last));
      chk("sub",    16'(o2ND_PART_SUBSEC), 16'(e.sub));
      chk("sector", 16'(oSECTOR),          16'(e.sec));
      chk("tw",     16'(oTW_ADDR),         16'(e.tw));
   endtask

   task automatic cycle(input logic st);
      iSTART = st;
      @(posedge iCLK);
      if (t < 0) begin
         if (st) t = 0;
      end else if (t >= RUN) begin
         t = -1;
      end else begin
         t++;
      end
      @(negedge iCLK);
      check_all();
   endtask

   task automatic do_reset();
      #2;
      iRESET = 1'b0;
      t = -1;
      #1;
      check_all();
      @(negedge iCLK);
      iRESET = 1'b1;
   endtask

   initial begin
      iRESET = 1'b0;
      iSTART = 1'b0;
      #1;
      check_all();
      @(negedge iCLK);
      iRESET = 1'b1;
      cycle(1'b0);

      // start at edge 0, stray starts in cycles 10 and 33, restart in 34
      for (int c = 1; c <= 40; c++)
         cycle(c == 1 || c == 11 || c == 34 || c == 35);

      // second run is 6 cycles in; reset lands in its cycle 12
      for (int c = 0; c < 5; c++) cycle(1'b0);
      do_reset();
      for (int c = 0; c < 3; c++) cycle(1'b0);
      cycle(1'b1);
      for (int c = 0; c < RUN + 3; c++) cycle(1'b0);

      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(299) == 0) do_reset();
         cycle($urandom_range(7) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
